// File: rtl/mlp_layer_sequencer.sv
// Streams a multi-layer job (activations, then per-layer weight bytes) into mlp_top,
// drives its FIFO/start controls and returns layer-tagged accumulator results.
module mlp_layer_sequencer #(
  parameter int unsigned ROWS       = 2,
  parameter int unsigned ACTS       = 2,
  parameter int unsigned MAX_LAYERS = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_start,
  input  logic [2:0]         cmd_num_layers,
  input  logic               cmd_abort,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [15:0]        act_data,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [7:0]         w_data,
  output logic               wf_push_col0,
  output logic               wf_push_col1,
  output logic [7:0]         wf_data,
  output logic               wf_reset,
  output logic               init_act_valid,
  output logic [15:0]        init_act_data,
  output logic               start_mlp,
  output logic               weights_ready,
  input  logic               mlp_layer_complete,
  input  logic               mlp_acc_valid,
  input  logic signed [31:0] mlp_acc0,
  input  logic signed [31:0] mlp_acc1,
  output logic               res_valid,
  output logic signed [31:0] res_acc0,
  output logic signed [31:0] res_acc1,
  output logic [2:0]         res_layer,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned WBYTES = 2 * ROWS;
  localparam int unsigned ACW    = $clog2(ACTS + 1);
  localparam int unsigned WCW    = $clog2(WBYTES + 1);
  localparam int unsigned WDW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLR, LOAD_ACT, LOAD_W, RUN, DONE} state_t;

  state_t         state;
  logic [ACW-1:0] act_cnt;
  logic [WCW-1:0] w_cnt;
  logic [WDW-1:0] wdog;
  logic [2:0]     num_layers;
  logic [2:0]     layer_idx;

  assign act_ready     = (state == LOAD_ACT);
  assign w_ready       = (state == LOAD_W);
  assign weights_ready = (state == RUN);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      act_cnt        <= '0;
      w_cnt          <= '0;
      wdog           <= '0;
      num_layers     <= '0;
      layer_idx      <= '0;
      wf_push_col0   <= 1'b0;
      wf_push_col1   <= 1'b0;
      wf_data        <= '0;
      wf_reset       <= 1'b0;
      init_act_valid <= 1'b0;
      init_act_data  <= '0;
      start_mlp      <= 1'b0;
      res_valid      <= 1'b0;
      res_acc0       <= '0;
      res_acc1       <= '0;
      res_layer      <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      wf_push_col0   <= 1'b0;
      wf_push_col1   <= 1'b0;
      wf_reset       <= 1'b0;
      init_act_valid <= 1'b0;
      start_mlp      <= 1'b0;
      res_valid      <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      // Abort bypasses the state case so any handshake in this cycle is dropped.
      if (cmd_abort && state != IDLE) begin
        state    <= IDLE;
        wf_reset <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (cmd_start) begin
              if (cmd_num_layers != 3'd0 && 32'(cmd_num_layers) <= MAX_LAYERS) begin
                num_layers <= cmd_num_layers;
                layer_idx  <= '0;
                wf_reset   <= 1'b1;
                state      <= CLR;
              end else begin
                error <= 1'b1;
              end
            end
          end
          CLR: begin
            act_cnt <= '0;
            state   <= LOAD_ACT;
          end
          LOAD_ACT: begin
            if (act_valid) begin
              init_act_valid <= 1'b1;
              init_act_data  <= act_data;
              if (act_cnt == ACW'(ACTS - 1)) begin
                w_cnt <= '0;
                state <= LOAD_W;
              end else begin
                act_cnt <= act_cnt + ACW'(1);
              end
            end
          end
          LOAD_W: begin
            if (w_valid) begin
              wf_data <= w_data;
              if (w_cnt < WCW'(ROWS)) wf_push_col0 <= 1'b1;
              else                    wf_push_col1 <= 1'b1;
              if (w_cnt == WCW'(WBYTES - 1)) begin
                wdog      <= '0;
                start_mlp <= (layer_idx == '0);
                state     <= RUN;
              end else begin
                w_cnt <= w_cnt + WCW'(1);
              end
            end
          end
          RUN: begin
            if (mlp_acc_valid) begin
              res_valid <= 1'b1;
              res_acc0  <= mlp_acc0;
              res_acc1  <= mlp_acc1;
              res_layer <= layer_idx;
            end
            if (mlp_layer_complete) begin
              layer_idx <= layer_idx + 3'd1;
              w_cnt     <= '0;
              if (layer_idx + 3'd1 == num_layers) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= LOAD_W;
              end
            end else begin
              if (wdog != WDW'(TIMEOUT)) wdog <= wdog + WDW'(1);
              if (wdog == WDW'(TIMEOUT - 1)) begin
                error    <= 1'b1;
                wf_reset <= 1'b1;
                state    <= IDLE;
              end
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
